// File: rtl/packet_buffer_read_arbiter.sv
// Round-robin read arbiter in front of packet_buffer_ram_driver.
// Grants one requester per cycle, or keeps a locked owner for a burst.
// Registers the winning address onto the RAM read port.
// Carries a requester tag alongside each read so the returned byte
// is steered back to the requester that issued it.
//
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   req, lock, addr - per-requester request, burst lock, flattened address
//   gnt             - one-hot grant, combinational in the request cycle
//   rvalid, rdata   - one-hot return strobe and shared return data
//   ram_read_*      - driver read port (req/addr out, ready/out in)
//   tag_error       - sticky: driver ready disagreed with the tag pipeline
module packet_buffer_read_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          ram_read_req,
  output logic [ADDR_WIDTH-1:0]         ram_read_addr,
  input  logic                          ram_read_ready,
  input  logic [DATA_WIDTH-1:0]         ram_read_out,
  output logic                          tag_error
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned SCAN_W = IDX_W + 1;

  typedef logic [SCAN_W-1:0] scan_t;
  typedef enum logic {FREE, LOCKED} state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    owner, owner_next;
  logic [IDX_W-1:0]    rr_ptr, rr_ptr_next;
  logic [IDX_W-1:0]    win;
  logic                grant_any;
  scan_t               scan_idx;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

  logic [IDX_W-1:0]    issue_idx;
  logic                tag_v [READ_LATENCY];
  logic [IDX_W-1:0]    tag_i [READ_LATENCY];
  logic                tag_out_v;
  logic [IDX_W-1:0]    tag_out_i;
  logic                mismatch;
  logic                err_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Arbitration: a locked owner that still requests wins outright;
  // otherwise scan upward from rr_ptr with wrap at NUM_REQ.
  always_comb begin
    win       = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    if (state == LOCKED && req[owner]) begin
      win       = owner;
      grant_any = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_idx = scan_t'({1'b0, rr_ptr}) + scan_t'(k);
        if (scan_idx >= scan_t'(NUM_REQ)) begin
          scan_idx = scan_idx - scan_t'(NUM_REQ);
        end
        if (!grant_any && req[scan_idx[IDX_W-1:0]]) begin
          grant_any = 1'b1;
          win       = scan_idx[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (reset && grant_any) begin
      gnt[win] = 1'b1;
    end
  end

  // Every grant either takes/holds the lock (rr_ptr frozen) or ends in
  // FREE with rr_ptr advanced past the winner; this covers the final
  // unlocked beat of a burst as well as ordinary grants.
  always_comb begin
    state_next  = FREE;
    owner_next  = owner;
    rr_ptr_next = rr_ptr;
    if (grant_any) begin
      if (lock[win]) begin
        state_next = LOCKED;
        owner_next = win;
      end else begin
        rr_ptr_next = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FREE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_read_req  <= 1'b0;
      ram_read_addr <= '0;
      issue_idx     <= '0;
    end else begin
      ram_read_req <= grant_any;
      if (grant_any) begin
        ram_read_addr <= addr_arr[win];
        issue_idx     <= win;
      end
    end
  end

  // Tag pipeline fed from the issue register so the tag leaves it in
  // the same cycle the driver presents the matching byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < READ_LATENCY; s++) begin
        tag_v[s] <= 1'b0;
        tag_i[s] <= '0;
      end
    end else begin
      tag_v[0] <= ram_read_req;
      tag_i[0] <= issue_idx;
      for (int unsigned s = 1; s < READ_LATENCY; s++) begin
        tag_v[s] <= tag_v[s-1];
        tag_i[s] <= tag_i[s-1];
      end
    end
  end

  assign tag_out_v = tag_v[READ_LATENCY-1];
  assign tag_out_i = tag_i[READ_LATENCY-1];
  assign mismatch  = ram_read_ready ^ tag_out_v;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (mismatch) begin
      err_q <= 1'b1;
    end
  end

  // Flag shows in the offending cycle itself, then stays via err_q.
  assign tag_error = err_q | (mismatch & reset);

  // A mismatch needs ready != valid, so the AND below already drops rvalid.
  always_comb begin
    rvalid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rvalid[i] = ram_read_ready & tag_out_v & (tag_out_i == IDX_W'(i));
    end
  end

  assign rdata = ram_read_out;

endmodule

// File: doc/packet_buffer_read_arbiter.md
Name: packet_buffer_read_arbiter

Overview:
- Shares the single read port of packet_buffer_ram_driver between NUM_REQ requesters, for example the Ethernet TX framer, the decrypt engine and the debug dump.
- Performs round-robin arbitration with an optional lock for contiguous bursts.
- Registers the winning request onto the RAM read port.
- Carries a requester tag through a READ_LATENCY pipeline so each returned byte is steered to the requester that asked for it.

Parameters:
- NUM_REQ, 2, number of requesters, legal range 2..4.
- ADDR_WIDTH, 11, width of the packet buffer address (clog2 of PACKET_BUFFER_SIZE).
- DATA_WIDTH, 8, width of the read data (BYTE_LEN).
- READ_LATENCY, 2, must equal the driver's READ_LATENCY.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester read request
- lock  in  NUM_REQ  per-requester burst lock; sampled only while that requester holds the grant
- addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
- rvalid  out  NUM_REQ  one-hot, marks the returned data as belonging to requester i
- rdata  out  DATA_WIDTH  returned data, shared by all requesters
- ram_read_req  out  1  to driver read_req
- ram_read_addr  out  ADDR_WIDTH  to driver read_addr
- ram_read_ready  in  1  from driver read_ready
- ram_read_out  in  DATA_WIDTH  from driver read_out
- tag_error  out  1  sticky; flags a mismatch between ram_read_ready and the tag pipeline

Behaviour:
Reset (reset low, asynchronous):
- ram_read_req=0, ram_read_addr=0, tag pipeline cleared, rr_ptr=0, owner=none, tag_error=0.
- rvalid=0 and gnt=0 while reset is asserted.

Arbitration (combinational):
- If an owner exists and req[owner]=1: gnt=onehot(owner).
- Otherwise: gnt goes to the first asserted req scanning upward from rr_ptr, with wrap-around.
- No req asserted: gnt=0.
- gnt[i] implies req[i]; at most one gnt bit is set.

State (two states):
- FREE (owner=none) -> LOCKED when the granted requester i has lock[i]=1 in the grant cycle; owner<=i.
- LOCKED -> FREE on the first cycle where lock[owner]=0 or req[owner]=0.
  - If req[owner]=1 and lock=0 in that cycle, the owner is still granted that one final beat.
  - If req[owner]=0, arbitration that cycle is as in FREE.
- rr_ptr updates to (granted index + 1) mod NUM_REQ only on grant cycles where no lock is taken or held. While LOCKED, rr_ptr is frozen.

Issue path (registered):
- Grant in cycle t: ram_read_req=1 and ram_read_addr=addr of the winner in cycle t+1.
- No grant: ram_read_req=0 and ram_read_addr holds its last value.
- Throughput is one read per cycle; back-to-back grants to different requesters are allowed.

Tag pipeline:
- Tag = {valid, index}, shifted each cycle, READ_LATENCY stages, loaded alongside ram_read_req.
- Data for a grant in cycle t returns in cycle t+1+READ_LATENCY (3 with defaults).
- rvalid[i] = ram_read_ready & tag_out.valid & (tag_out.index==i); rdata=ram_read_out.
- rvalid and rdata are combinational from the driver outputs and the tag stage; no extra register.

Error handling:
- tag_error is set when ram_read_ready != tag_out.valid.
- It stays set until reset.
- rvalid is suppressed in any cycle where a mismatch occurs.

Boundary conditions:
- Requester drops req mid-lock: lock is released immediately and outstanding tags still deliver.
- Reset asserted with reads in flight: tags are cleared and the in-flight data is discarded. The driver's own delay line is not reset, so tag_error can set on a stale ram_read_ready; integration must keep both blocks in reset together.
- NUM_REQ not a power of two: rr_ptr wraps from NUM_REQ-1 to 0.
- addr is don't-care when req=0.

Test Plan:
- Single requester: req[0]=1, addr=0x010 for one cycle at t -> gnt[0]=1 at t; ram_read_req=1, addr 0x010 at t+1; rvalid[0]=1 with rdata=mem[0x010] at t+3.
- Round-robin: req=2'b11 held 4 cycles, no lock -> gnt sequence 01,10,01,10; rvalid returns in the same order, 3 cycles later each.
- Lock burst: requester 1 locks for 5 beats (addr 0x100..0x104) while req[0]=1 throughout -> gnt[1] for 5 cycles, then gnt[0]; rdata 0x100..0x104 arrive with rvalid[1] contiguously.
- Lock released mid-burst by dropping req[1] after 2 beats -> gnt[0] in the next cycle; both outstanding beats still deliver to requester 1.
- Asynchronous reset pulse while 2 reads are in flight -> all outputs 0 immediately; no rvalid afterwards; rr_ptr=0, so with req=11 after release the first grant goes to requester 0.
- Force ram_read_ready=1 with the tag pipeline empty -> tag_error=1 from that cycle, rvalid=0; tag_error stays high until reset.
